// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader for the writable instruction memory
//
// Accepts a header byte (word count) followed by three bytes per instruction
// (opcode, operand a, operand b), writes each assembled 20-bit word
// {op[3:0], a[7:0], b[7:0]} through a synchronous write port, zero-fills the
// remaining locations and holds the core until the full image is in place.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   begin a load (only honoured while idle)
//   in_valid  in   byte-stream valid
//   in_data   in   byte-stream data [7:0]
//   in_ready  out  byte-stream ready (combinational, from state)
//   wr_en     out  memory write strobe
//   wr_addr   out  memory write address [AW-1:0]
//   wr_data   out  memory write word [19:0]
//   busy      out  load in progress
//   done      out  sticky: last load completed
//   error     out  sticky: last load aborted
//   cpu_hold  out  pipeline hold request to the core

module instr_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [19:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

    // One extra bit so the address counter can reach DEPTH itself.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OP,
        S_A,
        S_B,
        S_FILL,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] addr_q, addr_d;
    logic [7:0]    count_q, count_d;
    logic [3:0]    op_q, op_d;
    logic [7:0]    a_q, a_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [19:0]   wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cpu_hold_q, cpu_hold_d;

    logic          accept;
    logic [CW-1:0] addr_inc;

    assign in_ready = (state_q == S_HDR) || (state_q == S_OP) ||
                      (state_q == S_A)   || (state_q == S_B);
    assign busy     = (state_q != S_IDLE);
    assign accept   = in_valid && in_ready;
    assign addr_inc = addr_q + 1'b1;

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cpu_hold = cpu_hold_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        op_d       = op_q;
        a_d        = a_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;
        cpu_hold_d = cpu_hold_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                    addr_d     = '0;
                    count_d    = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    count_d = in_data;
                    if (32'(in_data) > DEPTH) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end else if (in_data == 8'd0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_OP;
                    end
                end
            end
            S_OP: begin
                if (accept) begin
                    // Opcodes are 4 bits; a non-zero upper nibble means a corrupt stream.
                    if (in_data[7:4] != 4'd0) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end else begin
                        op_d    = in_data[3:0];
                        state_d = S_A;
                    end
                end
            end
            S_A: begin
                if (accept) begin
                    a_d     = in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[AW-1:0];
                    wr_data_d = {op_q, a_q, in_data};
                    addr_d    = addr_inc;
                    // addr counts words written, since every load starts at 0.
                    if (32'(addr_inc) < 32'(count_q)) begin
                        state_d = S_OP;
                    end else if (addr_inc == DEPTH_C) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q[AW-1:0];
                wr_data_d = 20'd0;
                addr_d    = addr_inc;
                if (addr_q == DEPTH_M1_C) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            op_q       <= op_d;
            a_q        <= a_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

endmodule
